seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the integer datapath ALU.
- Keeps the existing opcode map: add/sub/and/or/shifts/compare, signed or unsigned.
- Adds iterative multiply, divide and remainder, plus valid/ready handshakes on input and output.
- Sits between the issue stage and writeback. Multiplies and divides stall issue through in_ready instead of stretching the cycle.

Parameters:
- WIDTH, 32, operand/result width in bits; minimum 8.
- SHW, $clog2(WIDTH), shift-amount width, derived; shift amount = B[SHW-1:0].

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  high only in IDLE.
- op  in  4  opcode: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLL, 0101 SRL, 0110 SRA, 0111 GT, 1000 LT, 1001 MUL, 1010 DIV, 1011 REM; others undefined.
- mode  in  1  1 = signed, 0 = unsigned.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  primary result; the quotient for DIV.
- result_hi  out  WIDTH  MUL high half; 0 for every other op.
- overflow  out  1  overflow flag.
- zero  out  1  result == 0.
- div_by_zero  out  1  divisor was 0 (DIV/REM only).

Behaviour:
- Reset: state=IDLE; out_valid, result, result_hi and all flags = 0; in_ready = 1 on the first cycle after reset.
- Reset mid-operation aborts the operation. Nothing is output and the partial result is discarded.
- FSM is IDLE -> (BUSY) -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - in_valid latches op/mode/a/b.
  - Single-cycle ops compute and register in the same edge, then go to DONE.
  - MUL/DIV/REM load the iterative unit, set count=WIDTH, go to BUSY.
- BUSY:
  - in_ready=0.
  - One shift-add (MUL) or one restoring step (DIV/REM) per cycle; count decrements.
  - At count==1 the final step registers the result and moves to DONE.
- DONE:
  - out_valid=1 and outputs held stable.
  - On out_ready, go to IDLE on the next edge.
  - in_valid is ignored; there is no acceptance overlap.
- Latency, acceptance edge to out_valid:
  - Single-cycle ops: 1 cycle.
  - MUL/DIV/REM: WIDTH+1 cycles.
  - Best-case throughput: one op every 2 cycles.
- ADD/SUB:
  - Signed overflow: operand signs agree (B inverted for SUB) and the result sign differs.
  - Unsigned overflow: carry out on ADD, borrow on SUB.
- SLL/SRL/SRA: use B[SHW-1:0]; overflow=0.
- GT/LT: result = 1 or 0, signed or unsigned per mode.
- MUL:
  - Full 2*WIDTH product as {result_hi, result}.
  - Signed mode multiplies magnitudes and negates at the end.
  - overflow=1 when result_hi is not the sign-extension (signed) or zero-extension (unsigned) of result.
- DIV/REM:
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - b==0: div_by_zero=1, result = all ones (DIV) or a (REM), still WIDTH+1 cycles.
  - Signed MIN / -1: result = MIN (DIV) or 0 (REM), overflow=1.
- zero: computed from result for every op.
- Undefined opcode: result=0, flags=0, 1-cycle latency.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD..OP_REM.
  - MODE_SIGNED / MODE_UNSIGNED.
  - FSM state encoding S_IDLE/S_BUSY/S_DONE.
- Sub-module alu_muldiv_iter #(WIDTH) contains:
  - start, is_div, signed and operand inputs.
  - Counter and shift registers.
  - A done pulse plus quo/rem/prod outputs.
- The top module owns the FSM, single-cycle ops, flags and the handshake.

Test Plan (WIDTH=32):
- ADD signed, a=0x7FFFFFFF, b=1 -> result 0x80000000, overflow=1, zero=0; out_valid exactly 1 cycle after acceptance.
- MUL signed, a=0xFFFFFFFD (-3), b=7 -> result 0xFFFFFFEB, result_hi 0xFFFFFFFF, overflow=0; out_valid 33 cycles after acceptance; in_ready=0 throughout.
- DIV signed, a=-7, b=2 -> result 0xFFFFFFFD. REM with the same operands -> result 0xFFFFFFFF. DIV unsigned, a=5, b=0 -> result 0xFFFFFFFF, div_by_zero=1.
- SRA a=0x80000000, b=4 -> 0xF8000000. SUB unsigned, a=3, b=5 -> 0xFFFFFFFE, overflow=1.
- Backpressure: out_ready held 0 for 5 cycles with in_valid=1 and new operands -> result stable, out_valid=1, in_ready=0, new op not accepted until the cycle after out_ready rises.
- Reset asserted for 1 cycle at BUSY cycle 10 of a MUL -> next cycle out_valid=0, in_ready=1; following ADD 2+3 -> 5 with no stale result_hi.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential integer ALU.
//   - opcode map (OP_ADD .. OP_REM), unchanged from the single-cycle ALU
//   - mode encoding (signed / unsigned)
//   - control FSM state encoding
//   - is_iter_op(): opcodes served by the iterative multiply/divide unit
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRL = 4'h5;
  localparam logic [3:0] OP_SRA = 4'h6;
  localparam logic [3:0] OP_GT  = 4'h7;
  localparam logic [3:0] OP_LT  = 4'h8;
  localparam logic [3:0] OP_MUL = 4'h9;
  localparam logic [3:0] OP_DIV = 4'hA;
  localparam logic [3:0] OP_REM = 4'hB;

  localparam logic MODE_SIGNED   = 1'b1;
  localparam logic MODE_UNSIGNED = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_iter_op(input logic [3:0] opc);
    return (opc == OP_MUL) || (opc == OP_DIV) || (opc == OP_REM);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative multiply / restoring divide, one bit per cycle.
//   clk, rst         : clock, synchronous active-high reset (aborts any run)
//   start            : load operands and begin a WIDTH-step run
//   is_div           : 1 = divide (quotient + remainder), 0 = multiply
//   is_signed        : operands are two's complement
//   opa, opb         : dividend/multiplier, divisor/multiplicand
//   done             : high in the cycle whose edge performs the final step
//   quo, rem, prod   : results of the final step, valid while done is high
//
// Signed operands are reduced to magnitudes at start; the sign fix-up is
// applied combinationally to the final step's outputs so the caller can
// register finished results on the same edge as the last step.
module alu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_div,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  output logic               done,
  output logic [WIDTH-1:0]   quo,
  output logic [WIDTH-1:0]   rem,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc;    // product high half / partial remainder
  logic [WIDTH-1:0] sh;     // multiplier bits / dividend bits -> quotient
  logic [WIDTH-1:0] mag_b;  // multiplicand / divisor magnitude
  logic             div_r;
  logic             neg_q;  // negate product / quotient
  logic             neg_r;  // negate remainder (dividend was negative)

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign a_neg = is_signed & opa[WIDTH-1];
  assign b_neg = is_signed & opb[WIDTH-1];
  assign a_mag = a_neg ? -opa : opa;
  assign b_mag = b_neg ? -opb : opb;

  logic [WIDTH:0]   add_sum, rem_t, rem_diff;
  logic [WIDTH-1:0] acc_nx, sh_nx;
  logic [2*WIDTH-1:0] prod_mag;

  always_comb begin
    add_sum  = {1'b0, acc} + {1'b0, mag_b};
    rem_t    = {acc, sh[WIDTH-1]};
    rem_diff = rem_t - {1'b0, mag_b};
    acc_nx   = acc;
    sh_nx    = sh;
    if (div_r) begin
      // Restoring step: keep the difference only if it did not borrow.
      if (!rem_diff[WIDTH]) acc_nx = rem_diff[WIDTH-1:0];
      else                  acc_nx = rem_t[WIDTH-1:0];
      sh_nx = {sh[WIDTH-2:0], ~rem_diff[WIDTH]};
    end else begin
      // Right-shifting shift-add: {acc, sh} converges to the product.
      if (sh[0]) {acc_nx, sh_nx} = {add_sum, sh[WIDTH-1:1]};
      else       {acc_nx, sh_nx} = {1'b0, acc, sh[WIDTH-1:1]};
    end
  end

  assign prod_mag = {acc_nx, sh_nx};
  assign prod     = neg_q ? -prod_mag : prod_mag;
  assign quo      = neg_q ? -sh_nx : sh_nx;
  assign rem      = neg_r ? -acc_nx : acc_nx;
  assign done     = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      acc   <= '0;
      sh    <= '0;
      mag_b <= '0;
      div_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (start) begin
      cnt   <= CW'(WIDTH);
      acc   <= '0;
      sh    <= a_mag;
      mag_b <= b_mag;
      div_r <= is_div;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      acc <= acc_nx;
      sh  <= sh_nx;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle integer ALU with valid/ready handshakes on both sides.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operation offer; in_ready is high only in IDLE
//   op, mode, a, b        : opcode, signed(1)/unsigned(0), operands
//   out_valid / out_ready : result held in DONE until the consumer takes it
//   result, result_hi     : primary result (quotient for DIV), MUL high half
//   overflow, zero, div_by_zero : status flags for the held result
//
// Single-cycle ops are computed from the live inputs and registered on the
// accepting edge. MUL/DIV/REM hand off to alu_muldiv_iter and finish
// WIDTH edges later. All outputs are registered.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             overflow,
  output logic             zero,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [3:0]       op_r;
  logic             mode_r;
  logic [WIDTH-1:0] a_r, b_r;

  logic is_signed;
  assign is_signed = (mode == MODE_SIGNED);

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH:0]   add_w, sub_w;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ovf;

  always_comb begin
    add_w  = {1'b0, a} + {1'b0, b};
    sub_w  = {1'b0, a} - {1'b0, b};   // bit WIDTH is the unsigned borrow
    shamt  = b[SHW-1:0];
    sc_res = '0;
    sc_ovf = 1'b0;
    case (op)
      OP_ADD: begin
        sc_res = add_w[WIDTH-1:0];
        sc_ovf = is_signed ? ((a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]))
                           : add_w[WIDTH];
      end
      OP_SUB: begin
        sc_res = sub_w[WIDTH-1:0];
        sc_ovf = is_signed ? ((a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]))
                           : sub_w[WIDTH];
      end
      OP_AND: sc_res = a & b;
      OP_OR:  sc_res = a | b;
      OP_SLL: sc_res = a << shamt;
      OP_SRL: sc_res = a >> shamt;
      OP_SRA: sc_res = $signed(a) >>> shamt;
      OP_GT:  sc_res = {{(WIDTH-1){1'b0}}, is_signed ? ($signed(a) > $signed(b)) : (a > b)};
      OP_LT:  sc_res = {{(WIDTH-1){1'b0}}, is_signed ? ($signed(a) < $signed(b)) : (a < b)};
      default: ;  // iterative ops finish later; undefined opcodes yield 0
    endcase
  end

  // ---------------- iterative unit ----------------
  logic               it_start, it_done;
  logic [WIDTH-1:0]   it_quo, it_rem;
  logic [2*WIDTH-1:0] it_prod;

  assign it_start = (state == S_IDLE) && in_valid && is_iter_op(op);

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (it_start),
    .is_div    ((op == OP_DIV) || (op == OP_REM)),
    .is_signed (is_signed),
    .opa       (a),
    .opb       (b),
    .done      (it_done),
    .quo       (it_quo),
    .rem       (it_rem),
    .prod      (it_prod)
  );

  // Final values for the iterative ops, from the latched request.
  logic [WIDTH-1:0] fin_res, fin_hi;
  logic             fin_ovf, fin_dbz, b_zero;

  always_comb begin
    fin_res = '0;
    fin_hi  = '0;
    fin_ovf = 1'b0;
    fin_dbz = 1'b0;
    b_zero  = (b_r == '0);
    if (op_r == OP_MUL) begin
      fin_res = it_prod[WIDTH-1:0];
      fin_hi  = it_prod[2*WIDTH-1:WIDTH];
      fin_ovf = (mode_r == MODE_SIGNED) ? (fin_hi != {WIDTH{fin_res[WIDTH-1]}})
                                        : (fin_hi != '0);
    end else begin
      // Divide by zero ran the full iteration count; override its output.
      fin_dbz = b_zero;
      fin_ovf = (mode_r == MODE_SIGNED) && (a_r == MIN_VAL) && (b_r == '1);
      if (b_zero) fin_res = (op_r == OP_DIV) ? '1 : a_r;
      else        fin_res = (op_r == OP_DIV) ? it_quo : it_rem;
    end
  end

  // ---------------- control FSM + output registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= '0;
      result_hi   <= '0;
      overflow    <= 1'b0;
      zero        <= 1'b0;
      div_by_zero <= 1'b0;
      op_r        <= '0;
      mode_r      <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            op_r     <= op;
            mode_r   <= mode;
            a_r      <= a;
            b_r      <= b;
            in_ready <= 1'b0;
            if (is_iter_op(op)) begin
              state <= S_BUSY;
            end else begin
              state       <= S_DONE;
              out_valid   <= 1'b1;
              result      <= sc_res;
              result_hi   <= '0;
              overflow    <= sc_ovf;
              zero        <= (sc_res == '0);
              div_by_zero <= 1'b0;
            end
          end
        end
        S_BUSY: begin
          if (it_done) begin
            state       <= S_DONE;
            out_valid   <= 1'b1;
            result      <= fin_res;
            result_hi   <= fin_hi;
            overflow    <= fin_ovf;
            zero        <= (fin_res == '0);
            div_by_zero <= fin_dbz;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed cases with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model built on 64-bit integer arithmetic.
module tb_seq_alu;

  localparam int WIDTH = 32;
  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;
  localparam longint MAXU = 64'sd4294967295;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, mode;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        in_ready, out_valid, overflow, zero, div_by_zero;
  logic [31:0] result, result_hi;

  int n_chk = 0;
  int n_fail = 0;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .mode(mode), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi),
    .overflow(overflow), .zero(zero), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] res;
    logic [31:0] hi;
    logic        ovf;
    logic        dbz;
  } exp_t;

  function automatic int lat_of(input logic [3:0] o);
    return (o == 4'd9 || o == 4'd10 || o == 4'd11) ? 33 : 1;
  endfunction

  function automatic exp_t model(input logic [3:0] o, input logic md,
                                 input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint sx, sy, r, q, rm;
    longint unsigned ux, uy, up;
    e  = '0;
    sx = md ? longint'($signed(x)) : longint'(x);
    sy = md ? longint'($signed(y)) : longint'(y);
    ux = 64'(x);
    uy = 64'(y);
    case (o)
      4'd0, 4'd1: begin
        r = (o == 4'd0) ? sx + sy : sx - sy;
        e.res = r[31:0];
        e.ovf = md ? (r > MAXS || r < MINS) : (r > MAXU || r < 0);
      end
      4'd2: e.res = x & y;
      4'd3: e.res = x | y;
      4'd4: e.res = x << y[4:0];
      4'd5: e.res = x >> y[4:0];
      4'd6: e.res = $signed(x) >>> y[4:0];
      4'd7: e.res = {31'b0, sx > sy};
      4'd8: e.res = {31'b0, sx < sy};
      4'd9: begin
        if (md) begin
          r = sx * sy;
          {e.hi, e.res} = r;
          e.ovf = (r > MAXS || r < MINS);
        end else begin
          up = ux * uy;
          {e.hi, e.res} = up;
          e.ovf = (up > 64'(MAXU));
        end
      end
      4'd10, 4'd11: begin
        if (y == 32'd0) begin
          e.dbz = 1'b1;
          e.res = (o == 4'd10) ? 32'hFFFF_FFFF : x;
        end else begin
          q  = sx / sy;
          rm = sx % sy;
          e.res = (o == 4'd10) ? q[31:0] : rm[31:0];
          e.ovf = md && (q > MAXS);
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  // Transaction-level expectation of the handshake state.
  exp_t m_exp, m_pend;
  logic m_ready, m_valid;
  int   m_wait;
  logic armed = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_ready <= 1'b1;
      m_valid <= 1'b0;
      m_wait  <= 0;
      m_exp   <= '0;
    end else if (m_ready && in_valid) begin
      m_ready <= 1'b0;
      if (lat_of(op) == 1) begin
        m_valid <= 1'b1;
        m_exp   <= model(op, mode, a, b);
      end else begin
        m_wait <= lat_of(op) - 1;
        m_pend <= model(op, mode, a, b);
      end
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
      if (m_wait == 1) begin
        m_valid <= 1'b1;
        m_exp   <= m_pend;
      end
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
      m_ready <= 1'b1;
    end
  end

  // Cycle compare against the model.
  always @(negedge clk) begin
    #1;
    if (armed && !rst) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      chk("in_ready", {31'b0, in_ready}, {31'b0, m_ready});
      if (m_valid && out_valid) begin
        chk("result", result, m_exp.res);
        chk("result_hi", result_hi, m_exp.hi);
        chk("overflow", {31'b0, overflow}, {31'b0, m_exp.ovf});
        chk("zero", {31'b0, zero}, {31'b0, m_exp.res == 32'd0});
        chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, m_exp.dbz});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [3:0] o, input logic md, input logic [31:0] x,
                       input logic [31:0] y, input int hold, input bit bp,
                       output logic [31:0] r, output logic [31:0] rh,
                       output logic fo, output logic fz, output logic fd, output int lat);
    int guard = 0;
    op = o; mode = md; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    while (in_ready !== 1'b1 && guard < 100) begin @(negedge clk); guard++; end
    if (guard >= 100) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed low");
    end
    @(negedge clk);
    in_valid = bp; op = 4'($urandom); mode = 1'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin @(negedge clk); lat++; end
    if (out_valid !== 1'b1) begin
      n_chk++; n_fail++;
      $display("FAIL result_timeout: out_valid never rose");
    end
    r = result; rh = result_hi; fo = overflow; fz = zero; fd = div_by_zero;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bp) begin op = 4'($urandom); a = $urandom; b = $urandom; end
      chk("hold_result", result, r);
      chk("hold_valid", {31'b0, out_valid}, 32'd1);
      chk("hold_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic dir(input string nm, input logic [3:0] o, input logic md,
                     input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] er, input logic [31:0] eh,
                     input logic eo, input logic ez, input logic ed, input int el);
    logic [31:0] r, rh;
    logic fo, fz, fd;
    int lat;
    issue(o, md, x, y, 0, 1'b0, r, rh, fo, fz, fd, lat);
    chk({nm, ".result"}, r, er);
    chk({nm, ".result_hi"}, rh, eh);
    chk({nm, ".overflow"}, {31'b0, fo}, {31'b0, eo});
    chk({nm, ".zero"}, {31'b0, fz}, {31'b0, ez});
    chk({nm, ".div_by_zero"}, {31'b0, fd}, {31'b0, ed});
    chk({nm, ".latency"}, lat, el);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r, rh;
    logic fo, fz, fd;
    int lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; mode = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    armed = 1'b1;
    chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst.result", result, 32'd0);
    chk("rst.result_hi", result_hi, 32'd0);
    chk("rst.flags", {29'b0, overflow, zero, div_by_zero}, 32'd0);

    //  name         op     md    a             b            result        hi            o  z  d  lat
    dir("add_ovf",   4'd0,  1'b1, 32'h7FFFFFFF, 32'd1,       32'h80000000, 32'd0,        1, 0, 0, 1);
    dir("mul_neg",   4'd9,  1'b1, 32'hFFFFFFFD, 32'd7,       32'hFFFFFFEB, 32'hFFFFFFFF, 0, 0, 0, 33);
    dir("div_neg",   4'd10, 1'b1, 32'hFFFFFFF9, 32'd2,       32'hFFFFFFFD, 32'd0,        0, 0, 0, 33);
    dir("rem_neg",   4'd11, 1'b1, 32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 32'd0,        0, 0, 0, 33);
    dir("div_zero",  4'd10, 1'b0, 32'd5,        32'd0,       32'hFFFFFFFF, 32'd0,        0, 0, 1, 33);
    dir("rem_zero",  4'd11, 1'b1, 32'hFFFFFFF9, 32'd0,       32'hFFFFFFF9, 32'd0,        0, 0, 1, 33);
    dir("sra",       4'd6,  1'b1, 32'h80000000, 32'd4,       32'hF8000000, 32'd0,        0, 0, 0, 1);
    dir("sub_borrow",4'd1,  1'b0, 32'd3,        32'd5,       32'hFFFFFFFE, 32'd0,        1, 0, 0, 1);
    dir("div_minm1", 4'd10, 1'b1, 32'h80000000, 32'hFFFFFFFF,32'h80000000, 32'd0,        1, 0, 0, 33);
    dir("rem_minm1", 4'd11, 1'b1, 32'h80000000, 32'hFFFFFFFF,32'd0,        32'd0,        1, 1, 0, 33);
    dir("mul_u_ovf", 4'd9,  1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,32'd1,        32'hFFFFFFFE, 1, 0, 0, 33);
    dir("lt_signed", 4'd8,  1'b1, 32'hFFFFFFFF, 32'd1,       32'd1,        32'd0,        0, 0, 0, 1);
    dir("undef_op",  4'd13, 1'b0, 32'h1234,     32'h5678,    32'd0,        32'd0,        0, 1, 0, 1);

    // Backpressure: consumer stalls 5 cycles while new operands are offered.
    issue(4'd0, 1'b0, 32'd10, 32'd20, 5, 1'b1, r, rh, fo, fz, fd, lat);
    chk("bp.result", r, 32'd30);
    dir("bp_next",   4'd3,  1'b0, 32'hF0,       32'h0F,      32'hFF,       32'd0,        0, 0, 0, 1);

    // Reset at BUSY cycle 10 of a multiply.
    op = 4'd9; mode = 1'b1; a = 32'd123; b = 32'd456; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid.busy_ready", {31'b0, in_ready}, 32'd0);
    chk("mid.busy_valid", {31'b0, out_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid.rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid.rst_ready", {31'b0, in_ready}, 32'd1);
    chk("mid.rst_hi", result_hi, 32'd0);
    dir("post_rst",  4'd0,  1'b1, 32'd2,        32'd3,       32'd5,        32'd0,        0, 0, 0, 1);

    // Randomized traffic; the compare process checks every cycle.
    for (int i = 0; i < 150; i++) begin
      logic [3:0] ro;
      ro = 4'($urandom_range(0, 15));
      issue(ro, 1'($urandom), pick(), pick(), $urandom_range(0, 3),
            ($urandom_range(0, 3) == 0), r, rh, fo, fz, fd, lat);
      chk("rand.latency", lat, lat_of(ro));
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
